router_input_unit: RTL and testbench

- Per-input-port front end of the mesh router.
- Buffers incoming flits in a small FIFO and decodes the HEADER flit with XY routing.
- Drives a one-hot request plus the head flit's type and length toward the per-output round-robin arbiters.
- Dequeues one flit per cycle while the routed output port grants it and the crossbar accepts.

---
 rtl/router_input_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_router_input_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_input_unit.sv
// router_input_unit_fifo: flit store of DEPTH entries with a peekable head (pop_dat_o reads storage directly).
// Latency: a pushed flit is visible at the head one cycle after the push when the store was empty.
// Backpressure: push_rdy_o = !full, independent of a same-cycle pop; pop is honoured only when non-empty.
module router_input_unit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld_i,
  output logic             push_rdy_o,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic             pop_vld_o,
  input  logic             pop_rdy_i,
  output logic [WIDTH-1:0] pop_dat_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty;
  logic             push_fire, pop_fire;

  assign full       = (count_q == CNT_FULL);
  assign empty      = (count_q == '0);
  assign push_rdy_o = !full;
  assign pop_vld_o  = !empty;
  assign pop_dat_o  = mem_q[rd_ptr_q];
  assign push_fire  = push_vld_i && !full;
  assign pop_fire   = pop_rdy_i && !empty;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the store (contents become unreachable).
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; entries need no reset because the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end
endmodule

// router_input_unit: per-input-port front end -- buffers flits, XY-routes the head HEADER, requests one output port.
// Latency: out_req rises one cycle after a HEADER reaches the FIFO head; then one flit per cycle while granted.
// Backpressure: in_ready = !full (a same-cycle dequeue does not free a slot); head held until (grant & route) && out_ready.
// Build option: define INPUT_UNIT_PKT_COUNT_EN for a saturating forwarded-packet counter on pkt_count.
module router_input_unit #(
  parameter int DEPTH = 4,
  parameter int CUR_X = 0,
  parameter int CUR_Y = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_flit,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  grant,
  input  logic        out_ready,
  output logic [31:0] out_flit,
  output logic [2:0]  out_flit_type,
  output logic [11:0] out_length,
  output logic [4:0]  out_req,
  output logic        err,
  output logic [15:0] pkt_count
);
  localparam logic [3:0] CX = 4'(CUR_X);
  localparam logic [3:0] CY = 4'(CUR_Y);

  localparam logic [2:0] T_HEADER = 3'b001;
  localparam logic [2:0] T_TAIL   = 3'b100;

  // One-hot output ports: bit0=L, 1=N, 2=E, 3=S, 4=W.
  localparam logic [4:0] P_L = 5'b00001;
  localparam logic [4:0] P_N = 5'b00010;
  localparam logic [4:0] P_E = 5'b00100;
  localparam logic [4:0] P_S = 5'b01000;
  localparam logic [4:0] P_W = 5'b10000;

  typedef enum logic {
    S_IDLE,
    S_ROUTE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  route_q, route_d;
  logic [11:0] length_q, length_d;
  logic        err_q, err_d;

  logic        fifo_vld;
  logic        fifo_rdy;
  logic [31:0] head_flit;
  logic [2:0]  head_type;
  logic        deq;
  logic        tail_deq;
  logic [4:0]  req;
  logic [4:0]  xy_route;
  logic [4:0]  dx_diff;
  logic [4:0]  dy_diff;

  router_input_unit_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (in_valid),
    .push_rdy_o (fifo_rdy),
    .push_dat_i (in_flit),
    .pop_vld_o  (fifo_vld),
    .pop_rdy_i  (deq),
    .pop_dat_o  (head_flit)
  );

  assign head_type = head_flit[31:29];

  // XY decode of the head flit: X is resolved first, then Y (Y grows southward).
  // Differences are taken one bit wider so the top bit is a borrow (dst < cur).
  always_comb begin
    dx_diff  = {1'b0, head_flit[28:25]} - {1'b0, CX};
    dy_diff  = {1'b0, head_flit[24:21]} - {1'b0, CY};
    xy_route = P_L;
    if (dx_diff != 5'd0) begin
      xy_route = dx_diff[4] ? P_W : P_E;
    end else if (dy_diff != 5'd0) begin
      xy_route = dy_diff[4] ? P_N : P_S;
    end
  end

  // Packet FSM: IDLE latches the route of a head HEADER (or discards stray flits), ROUTE streams to the granted port.
  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    length_d = length_q;
    err_d    = err_q;
    deq      = 1'b0;
    tail_deq = 1'b0;
    req      = 5'b00000;
    case (state_q)
      S_IDLE: begin
        if (fifo_vld) begin
          if (head_type == T_HEADER) begin
            // Header stays in the FIFO; it is the first flit forwarded in ROUTE.
            route_d  = xy_route;
            length_d = head_flit[11:0];
            state_d  = S_ROUTE;
          end else begin
            deq   = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      S_ROUTE: begin
        if (fifo_vld) begin
          req = route_q;
          // Only the grant bit of our own routed port counts.
          if ((|(grant & route_q)) && out_ready) begin
            deq = 1'b1;
            if (head_type == T_TAIL) begin
              tail_deq = 1'b1;
              route_d  = 5'b00000;
              state_d  = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and route/length/error registers; reset drops any partial packet.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      route_q  <= 5'b00000;
      length_q <= 12'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      route_q  <= route_d;
      length_q <= length_d;
      err_q    <= err_d;
    end
  end

  assign in_ready      = fifo_rdy;
  assign out_flit      = fifo_vld ? head_flit : 32'd0;
  assign out_flit_type = out_flit[31:29];
  assign out_length    = length_q;
  assign out_req       = req;
  assign err           = err_q;

`ifdef INPUT_UNIT_PKT_COUNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Forwarded-packet count: one per TAIL leaving in ROUTE, saturating at all-ones.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (tail_deq && (pkt_cnt_q != 16'hFFFF)) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_cnt_q <= 16'd0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_count = pkt_cnt_q;
`else
  logic pkt_cnt_unused;
  assign pkt_cnt_unused = tail_deq;
  assign pkt_count      = 16'd0;
`endif
endmodule

// File: tb/tb_router_input_unit.sv
// tb_router_input_unit: directed and random stimulus for router_input_unit against a queue-based packet model.
// Main instance sits at (0,0), DEPTH=4; a second instance at (2,2), DEPTH=2, exercises all five route directions.
// Inputs change on the falling edge; outputs are compared on the falling edge before new inputs are applied.
module tb_router_input_unit;
  localparam int DEPTH = 4;
  localparam int MX = 0;
  localparam int MY = 0;
  localparam logic [4:0] G_L = 5'b00001;
  localparam logic [4:0] G_N = 5'b00010;
  localparam logic [4:0] G_E = 5'b00100;
  localparam logic [4:0] G_S = 5'b01000;
  localparam logic [4:0] G_W = 5'b10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in_flit;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  grant;
  logic        out_ready;
  logic [31:0] out_flit;
  logic [2:0]  out_flit_type;
  logic [11:0] out_length;
  logic [4:0]  out_req;
  logic        err;
  logic [15:0] pkt_count;

  logic [31:0] b_flit;
  logic        b_valid;
  logic        b_in_ready;
  logic [4:0]  b_grant;
  logic        b_ordy;
  logic [31:0] b_out_flit;
  logic [2:0]  b_type;
  logic [11:0] b_len;
  logic [4:0]  b_out_req;
  logic        b_err;
  logic [15:0] b_pkt;

  router_input_unit #(.DEPTH(DEPTH), .CUR_X(MX), .CUR_Y(MY)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .grant(grant), .out_ready(out_ready), .out_flit(out_flit), .out_flit_type(out_flit_type),
    .out_length(out_length), .out_req(out_req), .err(err), .pkt_count(pkt_count)
  );

  router_input_unit #(.DEPTH(2), .CUR_X(2), .CUR_Y(2)) dut_b (
    .clk(clk), .rst(rst), .in_flit(b_flit), .in_valid(b_valid), .in_ready(b_in_ready),
    .grant(b_grant), .out_ready(b_ordy), .out_flit(b_out_flit), .out_flit_type(b_type),
    .out_length(b_len), .out_req(b_out_req), .err(b_err), .pkt_count(b_pkt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as a queue plus the packet currently being forwarded.
  logic [31:0] mq[$];
  bit          m_act;
  logic [4:0]  m_route;
  logic [11:0] m_len;
  bit          m_err;
  int          m_pkts;

  function automatic logic [31:0] mk_hdr(input int dx, input int dy, input int len);
    return {3'b001, 4'(dx), 4'(dy), 9'd0, 12'(len)};
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] t, input int pay);
    return {t, 29'(pay)};
  endfunction

  function automatic logic [4:0] xy_ref(input logic [31:0] h, input int cx, input int cy);
    int dx;
    int dy;
    dx = int'(h[28:25]);
    dy = int'(h[24:21]);
    if (dx > cx) return G_E;
    if (dx < cx) return G_W;
    if (dy > cy) return G_S;
    if (dy < cy) return G_N;
    return G_L;
  endfunction

  function automatic logic [15:0] exp_pkt();
`ifdef INPUT_UNIT_PKT_COUNT_EN
    return (m_pkts > 65535) ? 16'hFFFF : 16'(m_pkts);
`else
    return 16'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] h;
    logic [4:0]  r;
    h = (mq.size() > 0) ? mq[0] : 32'h0;
    r = (m_act && mq.size() > 0) ? m_route : 5'b0;
    chk("m_in_ready", in_ready, mq.size() < DEPTH);
    if (mq.size() > 0) chk("m_out_flit", out_flit, h);
    chk("m_out_type", out_flit_type, h[31:29]);
    chk("m_out_req", out_req, r);
    chk("m_out_length", out_length, m_len);
    chk("m_err", err, m_err);
    chk("m_pkt_count", pkt_count, exp_pkt());
  endtask

  task automatic model_step(input logic v, input logic [31:0] f, input logic [4:0] g, input logic o);
    bit enq;
    bit deq;
    logic [31:0] h;
    enq = v && (mq.size() < DEPTH);
    deq = 0;
    if (mq.size() > 0) begin
      h = mq[0];
      if (!m_act) begin
        if (h[31:29] == 3'b001) begin
          m_act   = 1;
          m_route = xy_ref(h, MX, MY);
          m_len   = h[11:0];
        end else begin
          deq   = 1;
          m_err = 1;
        end
      end else if (((g & m_route) != 5'b0) && o) begin
        deq = 1;
        if (h[31:29] == 3'b100) begin
          m_act = 0;
          m_pkts++;
        end
      end
    end
    if (deq) void'(mq.pop_front());
    if (enq) mq.push_back(f);
  endtask

  // One clock: compare against model, apply inputs, advance model, move to the next falling edge.
  task automatic cyc(input logic v, input logic [31:0] f, input logic [4:0] g, input logic o);
    check_model();
    in_valid  = v;
    in_flit   = f;
    grant     = g;
    out_ready = o;
    model_step(v, f, g, o);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    in_valid = 1'b0; in_flit = 32'h0; grant = 5'b0; out_ready = 1'b0;
    b_valid = 1'b0; b_flit = 32'h0; b_grant = 5'b0; b_ordy = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    mq.delete();
    m_act = 0; m_route = 5'b0; m_len = 12'h0; m_err = 0; m_pkts = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_req", out_req, 0);
    chk("rst_err", err, 0);
    chk("rst_out_type", out_flit_type, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_out_length", out_length, 0);
    chk("rst_pkt_count", pkt_count, 0);
    rst = 1'b1;
  endtask

  logic [31:0] b_hdr[7];
  logic [4:0]  b_exp[7];
  logic [31:0] src[$];

  initial begin
    logic [31:0] h1, b1, t1, pend[$];
    int sent;

    do_reset(2);

    // Second instance at (2,2): every direction, plus X-before-Y priority.
    b_hdr[0] = mk_hdr(3, 2, 1); b_exp[0] = G_E;
    b_hdr[1] = mk_hdr(1, 2, 1); b_exp[1] = G_W;
    b_hdr[2] = mk_hdr(2, 3, 1); b_exp[2] = G_S;
    b_hdr[3] = mk_hdr(2, 1, 1); b_exp[3] = G_N;
    b_hdr[4] = mk_hdr(2, 2, 1); b_exp[4] = G_L;
    b_hdr[5] = mk_hdr(3, 0, 1); b_exp[5] = G_E;
    b_hdr[6] = mk_hdr(0, 5, 1); b_exp[6] = G_W;
    for (int i = 0; i < 7; i++) begin
      b_flit = b_hdr[i]; b_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      b_flit = mk(3'b100, i);
      @(posedge clk); @(negedge clk);
      b_valid = 1'b0;
      chk($sformatf("b_route%0d", i), b_out_req, b_exp[i]);
      b_grant = 5'b11111; b_ordy = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      b_grant = 5'b0; b_ordy = 1'b0;
      chk($sformatf("b_idle%0d", i), b_out_req, 0);
    end

    // East-bound 3-flit packet streamed at one flit per cycle.
    h1 = mk_hdr(2, 0, 3); b1 = mk(3'b010, 29'h0BADF00);
    t1 = mk(3'b100, 29'h0C0FFEE);
    cyc(1, h1, G_E, 1);
    cyc(1, b1, G_E, 1);
    chk("e_req", out_req, G_E);
    chk("e_len", out_length, 3);
    chk("e_head_hdr", out_flit, h1);
    cyc(1, t1, G_E, 1);
    chk("e_head_body", out_flit, b1);
    cyc(0, 0, G_E, 1);
    chk("e_head_tail", out_flit, t1);
    cyc(0, 0, G_E, 1);
    chk("e_req_off", out_req, 0);

    // Local and south routes.
    cyc(1, mk_hdr(0, 0, 1), 0, 0);
    cyc(1, mk(3'b100, 1), 0, 0);
    chk("l_req", out_req, G_L);
    repeat (3) cyc(0, 0, G_L, 1);
    chk("l_req_off", out_req, 0);
    cyc(1, mk_hdr(0, 3, 2), 0, 0);
    cyc(1, mk(3'b100, 2), 0, 0);
    chk("s_req", out_req, G_S);
    chk("s_len", out_length, 2);
    repeat (3) cyc(0, 0, G_S, 1);

    // Fill with no grant: 4 accepted, 5th held upstream, then drain in order.
    cyc(1, mk_hdr(1, 0, 4), 0, 0);
    cyc(1, mk(3'b010, 11), 0, 0);
    cyc(1, mk(3'b010, 12), 0, 0);
    cyc(1, mk(3'b100, 13), 0, 0);
    chk("full_in_ready", in_ready, 0);
    cyc(1, mk_hdr(0, 0, 1), 0, 0);
    chk("full_still", in_ready, 0);
    pend.push_back(mk_hdr(0, 0, 1));
    pend.push_back(mk(3'b100, 14));
    sent = 0;
    for (int i = 0; i < 14; i++) begin
      if (sent < 2) begin
        bit acc;
        acc = mq.size() < DEPTH;
        cyc(1, pend[sent], G_E | G_L, 1);
        if (acc) sent++;
      end else begin
        cyc(0, 0, G_E | G_L, 1);
      end
    end
    chk("full_drain_sent", sent, 2);
    chk("full_drain_empty", in_ready, 1);
    chk("full_drain_req", out_req, 0);

    // Stray BODY in IDLE: discarded, err sticky, next packet still forwarded.
    cyc(1, mk(3'b010, 99), 0, 0);
    cyc(0, 0, 0, 0);
    chk("err_set", err, 1);
    cyc(1, mk_hdr(3, 0, 2), G_E, 1);
    cyc(1, mk(3'b100, 98), G_E, 1);
    repeat (4) cyc(0, 0, G_E, 1);
    chk("err_sticky", err, 1);
    chk("err_pkt_done", out_req, 0);

    // Reset in the middle of a 4-flit packet.
    cyc(1, mk_hdr(1, 0, 4), 0, 0);
    cyc(1, mk(3'b010, 21), 0, 0);
    do_reset(1);
    cyc(1, mk_hdr(0, 2, 5), 0, 0);
    cyc(0, 0, 0, 0);
    chk("fresh_req", out_req, G_S);
    chk("fresh_len", out_length, 5);
    cyc(1, mk(3'b100, 22), G_S, 1);
    repeat (3) cyc(0, 0, G_S, 1);

    // Three packets counted from reset.
    do_reset(2);
    for (int p = 0; p < 3; p++) begin
      cyc(1, mk_hdr(p % 2, p / 2, p + 1), 5'b11111, 1);
      cyc(1, mk(3'b100, p), 5'b11111, 1);
      repeat (3) cyc(0, 0, 5'b11111, 1);
    end
`ifdef INPUT_UNIT_PKT_COUNT_EN
    chk("pkt_count_3", pkt_count, 16'd3);
`else
    chk("pkt_count_off", pkt_count, 16'd0);
`endif

    // Random traffic: packets, stray flits, random valid/grant/ready.
    for (int i = 0; i < 2500; i++) begin
      logic v, o;
      logic [4:0] g;
      bit acc;
      if (src.size() == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          logic [2:0] t;
          t = 3'($urandom);
          if (t == 3'b001) t = 3'b010;
          src.push_back(mk(t, int'($urandom)));
        end else begin
          int nb;
          nb = $urandom_range(0, 3);
          src.push_back(mk_hdr(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                               int'($urandom_range(0, 4095))));
          for (int k = 0; k < nb; k++)
            src.push_back(mk(($urandom_range(0, 15) == 0) ? 3'b001 : 3'b010, int'($urandom)));
          src.push_back(mk(3'b100, int'($urandom)));
        end
      end
      v = ($urandom_range(0, 9) < 7);
      g = 5'($urandom);
      o = ($urandom_range(0, 3) != 0);
      acc = v && (mq.size() < DEPTH);
      cyc(v, src[0], g, o);
      if (acc) void'(src.pop_front());
    end
    repeat (20) cyc(0, 0, 5'b11111, 1);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
